// File: rtl/alarm_ctrl.sv
// Alarm controller: holds and edits the alarm time, arms/disarms, and sequences ringing.
// Optional snooze support is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_ctrl #(
  parameter int DEF_HOUR   = 1,
  parameter int DEF_MIN    = 10,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  input  logic       alarm_hit,
  output logic [5:0] alarm_hours,
  output logic [6:0] alarm_minutes,
  output logic       alarm_armed,
  output logic       ringing,
  output logic [1:0] edit_field
);

  // Every button and sec_tick is a single-cycle pulse with no handshake: it is
  // acted on at the clk edge where it is high and never held or queued.

  localparam int RW = $clog2(RING_SEC + 1);

`ifdef ALARM_SNOOZE_EN
  localparam int MW = $clog2(SNOOZE_MIN + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_H  = 3'd1,
    EDIT_M  = 3'd2,
    RINGING = 3'd3,
    SNOOZE  = 3'd4
  } state_t;

  logic [5:0]    snz_sec;
  logic [MW-1:0] snz_min;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_H  = 3'd1,
    EDIT_M  = 3'd2,
    RINGING = 3'd3
  } state_t;

  logic unused_snooze;
  assign unused_snooze = btn_snooze;
`endif

  state_t        state;
  logic [RW-1:0] ring_cnt;
  logic          hit_q;
  logic          hit_rise;

  // Only a fresh rise counts, so a hit level spanning a whole minute rings once.
  assign hit_rise = alarm_hit & ~hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      alarm_hours   <= 6'(DEF_HOUR);
      alarm_minutes <= 7'(DEF_MIN);
      alarm_armed   <= 1'b0;
      ringing       <= 1'b0;
      edit_field    <= 2'b00;
      ring_cnt      <= '0;
      hit_q         <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_sec       <= '0;
      snz_min       <= '0;
`endif
    end else begin
      hit_q <= alarm_hit;
      case (state)
        IDLE: begin
          if (hit_rise && alarm_armed) begin
            state    <= RINGING;
            ringing  <= 1'b1;
            ring_cnt <= '0;
          end else if (btn_mode) begin
            state      <= EDIT_H;
            edit_field <= 2'b01;
          end else if (btn_inc) begin
            alarm_armed <= ~alarm_armed;
          end
        end

        EDIT_H: begin
          if (btn_mode) begin
            state      <= EDIT_M;
            edit_field <= 2'b10;
          end else if (btn_inc) begin
            alarm_hours <= (alarm_hours == 6'd23) ? 6'd0 : alarm_hours + 6'd1;
          end
        end

        EDIT_M: begin
          if (btn_mode) begin
            state      <= IDLE;
            edit_field <= 2'b00;
          end else if (btn_inc) begin
            alarm_minutes <= (alarm_minutes == 7'd59) ? 7'd0 : alarm_minutes + 7'd1;
          end
        end

        RINGING: begin
          if (btn_stop) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
          end else if (btn_snooze) begin
            state    <= SNOOZE;
            ringing  <= 1'b0;
            ring_cnt <= '0;
            snz_sec  <= '0;
            snz_min  <= '0;
`endif
          end else if (sec_tick) begin
            if (ring_cnt == RW'(RING_SEC - 1)) begin
              state    <= IDLE;
              ringing  <= 1'b0;
              ring_cnt <= '0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end

`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (btn_stop) begin
            state <= IDLE;
          end else if (btn_inc) begin
            state       <= IDLE;
            alarm_armed <= 1'b0;
          end else if (sec_tick) begin
            if (snz_sec == 6'd59) begin
              snz_sec <= '0;
              if (snz_min == MW'(SNOOZE_MIN - 1)) begin
                snz_min  <= '0;
                state    <= RINGING;
                ringing  <= 1'b1;
                ring_cnt <= '0;
              end else begin
                snz_min <= snz_min + 1'b1;
              end
            end else begin
              snz_sec <= snz_sec + 6'd1;
            end
          end
        end
`endif

        default: begin
          state      <= IDLE;
          ringing    <= 1'b0;
          edit_field <= 2'b00;
        end
      endcase
    end
  end

  // Output registers must always agree with the state they are derived from.
  a_hours_range: assert property (@(posedge clk) disable iff (rst)
    alarm_hours < 6'd24);
  a_minutes_range: assert property (@(posedge clk) disable iff (rst)
    alarm_minutes < 7'd60);
  a_ringing_state: assert property (@(posedge clk) disable iff (rst)
    ringing == (state == RINGING));
  a_field_state: assert property (@(posedge clk) disable iff (rst)
    edit_field == ((state == EDIT_H) ? 2'b01 : (state == EDIT_M) ? 2'b10 : 2'b00));

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: stimulus pushes expected output snapshots into a
// queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_alarm_ctrl;

  localparam int W = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick, btn_mode, btn_inc, btn_stop, btn_snooze, alarm_hit;
  logic [5:0] alarm_hours;
  logic [6:0] alarm_minutes;
  logic       alarm_armed, ringing;
  logic [1:0] edit_field;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         check_en = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;

  alarm_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .sec_tick      (sec_tick),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .btn_stop      (btn_stop),
    .btn_snooze    (btn_snooze),
    .alarm_hit     (alarm_hit),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_armed   (alarm_armed),
    .ringing       (ringing),
    .edit_field    (edit_field)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic m, input logic i, input logic st, input logic sz, input logic tk);
    btn_mode = m; btn_inc = i; btn_stop = st; btn_snooze = sz; sec_tick = tk;
    step();
    btn_mode = 0; btn_inc = 0; btn_stop = 0; btn_snooze = 0; sec_tick = 0;
  endtask

  task automatic expect_out(input string nm, input logic [5:0] h, input logic [6:0] m,
                            input logic a, input logic r, input logic [1:0] f);
    exp_q.push_back({h, m, a, r, f});
    name_q.push_back(nm);
    check_en = 1'b1;
    @(negedge clk);
    #1;
    check_en = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (check_en) begin
      logic [W-1:0] got, exp_v;
      string nm;
      got = {alarm_hours, alarm_minutes, alarm_armed, ringing, edit_field};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor: output sampled with empty expected queue");
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got h=%0d m=%0d armed=%b ring=%b field=%b, expected h=%0d m=%0d armed=%b ring=%b field=%b",
                   nm, got[16:11], got[10:4], got[3], got[2], got[1:0],
                   exp_v[16:11], exp_v[10:4], exp_v[3], exp_v[2], exp_v[1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1; sec_tick = 0; btn_mode = 0; btn_inc = 0; btn_stop = 0; btn_snooze = 0; alarm_hit = 0;
    idle(2);
    rst = 0;
    expect_out("reset", 1, 10, 0, 0, 2'b00);

    // editing with wraparound
    press(1, 0, 0, 0, 0);
    expect_out("edit_h", 1, 10, 0, 0, 2'b01);
    repeat (22) press(0, 1, 0, 0, 0);
    expect_out("hours_23", 23, 10, 0, 0, 2'b01);
    press(0, 1, 0, 0, 0);
    expect_out("hours_wrap", 0, 10, 0, 0, 2'b01);
    press(1, 0, 0, 0, 0);
    expect_out("edit_m", 0, 10, 0, 0, 2'b10);
    repeat (49) press(0, 1, 0, 0, 0);
    expect_out("min_59", 0, 59, 0, 0, 2'b10);
    press(0, 1, 0, 0, 0);
    expect_out("min_wrap", 0, 0, 0, 0, 2'b10);
    press(1, 0, 0, 0, 0);
    expect_out("edit_exit", 0, 0, 0, 0, 2'b00);

    // mode beats inc in the same cycle
    press(1, 1, 0, 0, 0);
    expect_out("mode_wins", 0, 0, 0, 0, 2'b01);
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    expect_out("back_idle", 0, 0, 0, 0, 2'b00);

    // arm and ring with auto-stop
    press(0, 1, 0, 0, 0);
    expect_out("arm", 0, 0, 1, 0, 2'b00);
    alarm_hit = 1;
    step();
    expect_out("ring_latency", 0, 0, 1, 1, 2'b00);
    for (int t = 1; t <= 60; t++) begin
      idle(9);
      press(0, 0, 0, 0, 1);
      if (t == 59) expect_out("ring_59_ticks", 0, 0, 1, 1, 2'b00);
    end
    expect_out("auto_stop", 0, 0, 1, 0, 2'b00);
    idle(20);
    expect_out("no_retrigger", 0, 0, 1, 0, 2'b00);
    alarm_hit = 0;
    step();

    // manual stop, re-ring, ignored buttons
    alarm_hit = 1;
    step();
    expect_out("ring2", 0, 0, 1, 1, 2'b00);
    idle(4);
    press(0, 0, 1, 0, 0);
    expect_out("stop", 0, 0, 1, 0, 2'b00);
    idle(3);
    expect_out("stop_hold_hit", 0, 0, 1, 0, 2'b00);
    alarm_hit = 0;
    step();
    alarm_hit = 1;
    step();
    expect_out("re_ring", 0, 0, 1, 1, 2'b00);
    press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    expect_out("ring_ignores_btns", 0, 0, 1, 1, 2'b00);
`ifndef ALARM_SNOOZE_EN
    press(0, 0, 0, 1, 0);
    expect_out("snooze_ignored", 0, 0, 1, 1, 2'b00);
`endif
    press(0, 0, 1, 0, 0);
    expect_out("stop2", 0, 0, 1, 0, 2'b00);
    alarm_hit = 0;
    step();

    // disarmed alarm does not ring
    press(0, 1, 0, 0, 0);
    expect_out("disarm", 0, 0, 0, 0, 2'b00);
    alarm_hit = 1;
    idle(2);
    expect_out("disarmed_hit", 0, 0, 0, 0, 2'b00);
    alarm_hit = 0;
    step();

`ifdef ALARM_SNOOZE_EN
    // snooze for SNOOZE_MIN minutes then ring again
    press(0, 1, 0, 0, 0);
    alarm_hit = 1;
    step();
    alarm_hit = 0;
    expect_out("snz_ring", 0, 0, 1, 1, 2'b00);
    press(0, 0, 0, 1, 0);
    expect_out("snoozed", 0, 0, 1, 0, 2'b00);
    for (int t = 1; t <= 300; t++) begin
      press(0, 0, 0, 0, 1);
      step();
      if (t == 299) expect_out("snooze_299", 0, 0, 1, 0, 2'b00);
    end
    expect_out("snooze_expire", 0, 0, 1, 1, 2'b00);
    press(0, 0, 1, 1, 0);
    expect_out("stop_over_snooze", 0, 0, 1, 0, 2'b00);
    press(1, 0, 0, 0, 0);
    expect_out("idle_after_stop", 0, 0, 1, 0, 2'b01);
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    alarm_hit = 1;
    step();
    alarm_hit = 0;
    press(0, 0, 0, 1, 0);
    press(0, 1, 0, 0, 0);
    expect_out("snooze_disarm", 0, 0, 0, 0, 2'b00);
`endif

    // reset while ringing and while editing
    press(0, 1, 0, 0, 0);
    alarm_hit = 1;
    step();
    expect_out("ring_pre_rst", 0, 0, 1, 1, 2'b00);
    rst = 1;
    alarm_hit = 0;
    step();
    rst = 0;
    expect_out("rst_in_ring", 1, 10, 0, 0, 2'b00);
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    expect_out("edit_pre_rst", 2, 11, 0, 0, 2'b10);
    rst = 1;
    step();
    rst = 0;
    expect_out("rst_in_edit", 1, 10, 0, 0, 2'b00);

    // final report
    idle(2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
